fetch_ctrl: RTL and testbench

- Sequences instruction fetch: owns the program counter, issues requests to instruction memory through a req/ack handshake, and holds one fetched instruction for Instruction Decode (ID).
- Absorbs ID back-pressure (stall) and PC redirects from ID (taken conditional branches, flushes).
- Sits between the instruction-memory port and the IF/ID boundary, replacing free-running +4 PC update with a controlled sequencer.

---
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_fetch_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the instruction-memory req/ack
// handshake and holds one fetched instruction for decode, honouring stall and redirect.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ack,
   input  logic [31:0] im_data,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   output logic [31:0] pc
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

   localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [31:0] pc_r;
   logic [31:0] pc_nxt_s;
   logic [31:0] inst_out_r;
   logic [31:0] inst_out_nxt_s;
   logic [31:0] inst_pc_r;
   logic [31:0] inst_pc_nxt_s;
   logic        inst_valid_r;
   logic        inst_valid_nxt_s;
   logic        im_req_s;

   // Next-state, datapath updates and the memory request; redirect overrides everything.
   always_comb begin
      state_nxt_s      = state_r;
      pc_nxt_s         = pc_r;
      inst_out_nxt_s   = inst_out_r;
      inst_pc_nxt_s    = inst_pc_r;
      inst_valid_nxt_s = inst_valid_r;
      im_req_s         = 1'b0;

      if (redirect) begin
         // Any ack arriving with the redirect belongs to the abandoned path and is dropped.
         pc_nxt_s         = word_align(redirect_pc);
         inst_valid_nxt_s = 1'b0;
         state_nxt_s      = REQ;
      end else begin
         case (state_r)
            IDLE: begin
               state_nxt_s = REQ;
            end
            REQ: begin
               im_req_s = !(inst_valid_r && stall);
               if (im_req_s && im_ack) begin
                  inst_out_nxt_s   = im_data;
                  inst_pc_nxt_s    = pc_r;
                  inst_valid_nxt_s = 1'b1;
                  pc_nxt_s         = pc_r + 32'd4;
               end else if (inst_valid_r && !stall) begin
                  inst_valid_nxt_s = 1'b0;
               end else begin
                  inst_valid_nxt_s = inst_valid_r;
               end
               if (inst_valid_r && stall) begin
                  state_nxt_s = HOLD;
               end else begin
                  state_nxt_s = REQ;
               end
            end
            HOLD: begin
               if (!stall) begin
                  inst_valid_nxt_s = 1'b0;
                  state_nxt_s      = REQ;
               end else begin
                  state_nxt_s = HOLD;
               end
            end
            default: begin
               state_nxt_s      = IDLE;
               inst_valid_nxt_s = 1'b0;
            end
         endcase
      end
   end

   // State and output-slot registers; reset clears them without waiting for a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         pc_r         <= RESET_PC_ALIGNED;
         inst_out_r   <= 32'h0000_0000;
         inst_pc_r    <= 32'h0000_0000;
         inst_valid_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         pc_r         <= pc_nxt_s;
         inst_out_r   <= inst_out_nxt_s;
         inst_pc_r    <= inst_pc_nxt_s;
         inst_valid_r <= inst_valid_nxt_s;
      end
   end

   // The request is combinational only in registered state and control inputs, never im_data.
   assign im_req     = im_req_s;
   assign im_addr    = pc_r;
   assign pc         = pc_r;
   assign inst_out   = inst_out_r;
   assign inst_pc    = inst_pc_r;
   assign inst_valid = inst_valid_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: one instance with RESET_PC=0 under scripted stall,
// ack and redirect, plus a free-running instance with RESET_PC=FFFF_FFF8 for PC wrap.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0000_0000;
   logic        ack_tie = 1'b1;
   logic        ack_force = 1'b0;

   logic        im_req0, inst_valid0, im_ack0;
   logic [31:0] im_addr0, im_data0, inst_out0, inst_pc0, pc0;
   logic        im_req1, inst_valid1, im_ack1;
   logic [31:0] im_addr1, im_data1, inst_out1, inst_pc1, pc1;

   int checks_r = 0;
   int failures_r = 0;

   always #5 clk = ~clk;

   // Memory model: data equals the address; ack either tied to req or scripted.
   assign im_ack0  = ack_tie ? im_req0 : ack_force;
   assign im_data0 = im_addr0;
   assign im_ack1  = im_req1;
   assign im_data1 = im_addr1;

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut0 (
      .clk(clk), .reset(rst_n), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .im_req(im_req0), .im_addr(im_addr0),
      .im_ack(im_ack0), .im_data(im_data0), .inst_out(inst_out0),
      .inst_pc(inst_pc0), .inst_valid(inst_valid0), .pc(pc0)
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
      .clk(clk), .reset(rst_n), .stall(1'b0), .redirect(1'b0),
      .redirect_pc(32'h0000_0000), .im_req(im_req1), .im_addr(im_addr1),
      .im_ack(im_ack1), .im_data(im_data1), .inst_out(inst_out1),
      .inst_pc(inst_pc1), .inst_valid(inst_valid1), .pc(pc1)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_r++;
      if (got !== exp) begin
         failures_r++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_slot(input string tag, input logic v, input logic [31:0] ipc,
                             input logic [31:0] p);
      check_val({tag, "_valid"}, {31'd0, inst_valid0}, {31'd0, v});
      check_val({tag, "_inst_pc"}, inst_pc0, ipc);
      check_val({tag, "_pc"}, pc0, p);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check_val("rst_req", {31'd0, im_req0}, 32'd0);
      check_slot("rst", 1'b0, 32'h0, 32'h0);
      check_val("rst_inst_out", inst_out0, 32'h0);
      check_val("rst_pc1", pc1, 32'hFFFF_FFF8);

      // Release reset: one IDLE cycle, then back-to-back fetches
      rst_n = 1'b1;
      #1;
      check_val("idle_req", {31'd0, im_req0}, 32'd0);
      @(negedge clk);                                   // N1
      check_val("n1_req", {31'd0, im_req0}, 32'd1);
      check_slot("n1", 1'b0, 32'h0, 32'h0);
      check_val("n1_addr1", im_addr1, 32'hFFFF_FFF8);
      @(negedge clk);                                   // N2
      check_slot("n2", 1'b1, 32'h0, 32'h4);
      check_val("n2_out", inst_out0, 32'h0);
      check_val("n2_ipc1", inst_pc1, 32'hFFFF_FFF8);
      @(negedge clk);                                   // N3
      check_slot("n3", 1'b1, 32'h4, 32'h8);
      check_val("n3_out", inst_out0, 32'h4);
      check_val("n3_ipc1", inst_pc1, 32'hFFFF_FFFC);
      @(negedge clk);                                   // N4
      check_slot("n4", 1'b1, 32'h8, 32'hC);
      check_val("n4_out", inst_out0, 32'h8);
      check_val("n4_ipc1", inst_pc1, 32'h0);
      check_val("n4_pc1", pc1, 32'h4);

      // Stall three edges while holding inst_pc = 8
      stall = 1'b1;
      #1;
      check_val("stall_req_n4", {31'd0, im_req0}, 32'd0);
      for (int i = 0; i < 3; i++) begin                 // N5..N7
         @(negedge clk);
         check_slot("stall_hold", 1'b1, 32'h8, 32'hC);
         check_val("stall_out", inst_out0, 32'h8);
         check_val("stall_req", {31'd0, im_req0}, 32'd0);
         if (i == 0) check_val("n5_ipc1", inst_pc1, 32'h4);
      end
      stall = 1'b0;
      #1;
      check_val("hold_rel_req", {31'd0, im_req0}, 32'd0);
      @(negedge clk);                                   // N8: 8 consumed
      check_slot("n8", 1'b0, 32'h8, 32'hC);
      check_val("n8_req", {31'd0, im_req0}, 32'd1);
      check_val("n8_addr", im_addr0, 32'hC);
      @(negedge clk);                                   // N9: 12 fetched
      check_slot("n9", 1'b1, 32'hC, 32'h10);
      check_val("n9_out", inst_out0, 32'hC);

      // Delayed ack at pc = 16: request held three cycles
      ack_tie = 1'b0;
      ack_force = 1'b0;
      #1;
      check_val("dly0_req", {31'd0, im_req0}, 32'd1);
      check_val("dly0_addr", im_addr0, 32'h10);
      @(negedge clk);                                   // N10
      check_val("dly1_req", {31'd0, im_req0}, 32'd1);
      check_val("dly1_addr", im_addr0, 32'h10);
      check_slot("dly1", 1'b0, 32'hC, 32'h10);
      @(negedge clk);                                   // N11
      check_val("dly2_req", {31'd0, im_req0}, 32'd1);
      check_val("dly2_addr", im_addr0, 32'h10);
      check_slot("dly2", 1'b0, 32'hC, 32'h10);
      ack_force = 1'b1;
      @(negedge clk);                                   // N12
      check_slot("ack16", 1'b1, 32'h10, 32'h14);
      check_val("ack16_out", inst_out0, 32'h10);
      @(negedge clk);                                   // N13
      check_slot("n13", 1'b1, 32'h14, 32'h18);

      // Stall on inst_pc = 20, then redirect with ack still high
      stall = 1'b1;
      @(negedge clk);                                   // N14
      check_slot("n14", 1'b1, 32'h14, 32'h18);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0103;
      #1;
      check_val("redir_req", {31'd0, im_req0}, 32'd0);
      @(negedge clk);                                   // N15
      check_val("redir_valid", {31'd0, inst_valid0}, 32'd0);
      check_val("redir_pc", pc0, 32'h100);
      redirect = 1'b0;
      stall = 1'b0;
      ack_tie = 1'b1;
      #1;
      check_val("redir_addr", im_addr0, 32'h100);
      check_val("redir_req2", {31'd0, im_req0}, 32'd1);
      @(negedge clk);                                   // N16
      check_slot("n16", 1'b1, 32'h100, 32'h104);
      check_val("n16_out", inst_out0, 32'h100);
      check_val("n16_req", {31'd0, im_req0}, 32'd1);

      // Asynchronous reset mid-request
      rst_n = 1'b0;
      #1;
      check_val("arst_req", {31'd0, im_req0}, 32'd0);
      check_slot("arst", 1'b0, 32'h0, 32'h0);
      check_val("arst_pc1", pc1, 32'hFFFF_FFF8);
      check_val("arst_req1", {31'd0, im_req1}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
      $finish;
   end

endmodule
